// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 matrix keypad scanner with press/release debounce
//   clk           : clock, all state updates on the rising edge
//   rst           : synchronous active-high reset
//   Row[3:0]      : row returns of the currently driven column, active-high
//   Col[2:0]      : one-hot column drive, active-high
//   Key_Valid     : one-cycle pulse per qualified press
//   Key_Code[3:0] : 3*row+col of the last qualified press, 4'hF when none
//   Key_Held      : high from qualified press until qualified release
module keypad_scan #(
    parameter int SCAN_DIV     = 16,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Row,
    output logic [2:0] Col,
    output logic       Key_Valid,
    output logic [3:0] Key_Code,
    output logic       Key_Held
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state, state_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    row_sel, row_sel_n;
    logic [2:0]    col_n;
    logic          valid_n, held_n;
    logic [3:0]    code_n;
    logic          hit, dwell_end, cnt_end;
    logic [1:0]    low_row, col_idx;

    // hit tracks only the captured row; other rows are ignored once a key is locked
    assign hit       = Row[row_sel];
    assign dwell_end = dwell == DW'(SCAN_DIV - 1);
    assign cnt_end   = cnt == CW'(DEBOUNCE_CNT - 1);
    assign low_row   = Row[0] ? 2'd0 : Row[1] ? 2'd1 : Row[2] ? 2'd2 : 2'd3;
    assign col_idx   = Col[2] ? 2'd2 : Col[1] ? 2'd1 : 2'd0;

    always_comb begin
        state_n   = state;
        dwell_n   = dwell;
        cnt_n     = cnt;
        row_sel_n = row_sel;
        col_n     = Col;
        valid_n   = 1'b0;
        code_n    = Key_Code;
        held_n    = Key_Held;
        case (state)
            SCAN:
                if (!dwell_end) begin
                    dwell_n = dwell + DW'(1);
                end else if (|Row) begin
                    state_n   = DEBOUNCE;
                    row_sel_n = low_row;
                    cnt_n     = '0;
                end else begin
                    col_n   = {Col[1:0], Col[2]};
                    dwell_n = '0;
                end
            DEBOUNCE:
                if (!hit) begin
                    state_n = SCAN;
                    dwell_n = '0;
                end else if (cnt_end) begin
                    state_n = HELD;
                    valid_n = 1'b1;
                    code_n  = {2'b00, row_sel} * 4'd3 + {2'b00, col_idx};
                    held_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            HELD:
                if (!hit) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                end
            RELEASE:
                if (hit) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt_end) begin
                    state_n = SCAN;
                    col_n   = {Col[1:0], Col[2]};
                    dwell_n = '0;
                    held_n  = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            dwell     <= '0;
            cnt       <= '0;
            row_sel   <= 2'd0;
            Col       <= 3'b001;
            Key_Valid <= 1'b0;
            Key_Code  <= 4'hF;
            Key_Held  <= 1'b0;
        end else begin
            state     <= state_n;
            dwell     <= dwell_n;
            cnt       <= cnt_n;
            row_sel   <= row_sel_n;
            Col       <= col_n;
            Key_Valid <= valid_n;
            Key_Code  <= code_n;
            Key_Held  <= held_n;
        end
    end
endmodule
